seg7_scan_decoder: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface.
- Samples the active-low segment bus (SEG_IN, ABCDEFG+Dp, bit7 = A) and the active-low anode select (SA_IN); decodes each digit's pattern back to a 4-bit code.
- Holds a per-digit register for up to 4 digits; a digit changes only after its code is stable.
- Used as an on-board loopback monitor and checker for display drivers.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_decoder.sv | 123 ++++++++++++
 tb/tb_seg7_scan_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, decoded codes and scan FSM states
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low {A..G,Dp} pattern to {code, dp, err}
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] code,
    output logic       dp,
    output logic       err
);
    // Unknown patterns read as blank so the stability logic still sees a value
    always_comb begin
        err = 1'b0;
        dp = ~seg[0];
        case (seg[7:1])
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_E:     code = CODE_E;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_BLANK;
                err = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit codes from a multiplexed 7-segment bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int STABLE_CNT  = 3,
    parameter int TIMEOUT_CYC = 6000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  SEG_IN,
    input  logic [3:0]  SA_IN,
    input  logic        CLR_ERR,
    output logic [15:0] DIGITS,
    output logic [3:0]  DP_OUT,
    output logic        UPDATE,
    output logic        PAT_ERR,
    output logic        SA_ERR,
    output logic        ACTIVE
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [7:0] seg_m, seg_s;
    logic [3:0] sa_m, sa_s, sa_held;
    state_t state;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] to_cnt;
    logic [4:0] cand [4];
    logic [3:0] match [4];
    logic [3:0] dec_code, next_match;
    logic dec_dp, dec_err, sa_one, sa_multi, idle_eval, reload, do_upd;
    logic [1:0] n;
    logic [4:0] smp;

    seg7_pattern_decode u_dec (
        .seg  (seg_s),
        .code (dec_code),
        .dp   (dec_dp),
        .err  (dec_err)
    );

    // Two-flop synchronisers; idle (all high) out of reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            seg_m <= '1;
            seg_s <= '1;
            sa_m <= '1;
            sa_s <= '1;
        end else begin
            seg_m <= SEG_IN;
            seg_s <= seg_m;
            sa_m <= SA_IN;
            sa_s <= sa_m;
        end
    end

    // Anode classification, selected digit and stability decision for the sample
    always_comb begin
        sa_one = $onehot(~sa_s);
        sa_multi = !sa_one && sa_s != 4'hF;
        idle_eval = state == IDLE || (state == HOLD && sa_s != sa_held);
        reload = idle_eval || (state == SETTLE && sa_s != sa_held);
        n = !sa_held[0] ? 2'd0 : !sa_held[1] ? 2'd1 : !sa_held[2] ? 2'd2 : 2'd3;
        smp = {dec_code, dec_dp};
        next_match = smp != cand[n] ? 4'd1 : match[n] == 4'(STABLE_CNT) ? match[n] : match[n] + 4'd1;
        do_upd = next_match == 4'(STABLE_CNT) && smp != {DIGITS[{n, 2'b00} +: 4], DP_OUT[n]};
    end

    // Scan FSM with per-digit candidate/match tracking and sticky error flags
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            sa_held <= '1;
            settle_cnt <= '0;
            DIGITS <= 16'hFFFF;
            DP_OUT <= '0;
            UPDATE <= 1'b0;
            PAT_ERR <= 1'b0;
            SA_ERR <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cand[i] <= {CODE_BLANK, 1'b0};
                match[i] <= '0;
            end
        end else begin
            UPDATE <= 1'b0;
            PAT_ERR <= (state == SAMPLE && dec_err) || (PAT_ERR && !CLR_ERR);
            SA_ERR <= (idle_eval && sa_multi) || (SA_ERR && !CLR_ERR);
            if (reload) begin
                state <= sa_one ? SETTLE : IDLE;
                sa_held <= sa_s;
                settle_cnt <= SW'(1);
            end else if (state == SETTLE) begin
                if (settle_cnt == SW'(SETTLE_CYC - 1))
                    state <= SAMPLE;
                else
                    settle_cnt <= settle_cnt + SW'(1);
            end else if (state == SAMPLE) begin
                state <= HOLD;
                cand[n] <= smp;
                match[n] <= next_match;
                if (do_upd) begin
                    DIGITS[{n, 2'b00} +: 4] <= smp[4:1];
                    DP_OUT[n] <= smp[0];
                    UPDATE <= 1'b1;
                end
            end
        end
    end

    // Activity timeout: restarted by every sample, holds at its terminal count
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            to_cnt <= '0;
            ACTIVE <= 1'b0;
        end else if (state == SAMPLE) begin
            to_cnt <= '0;
            ACTIVE <= 1'b1;
        end else if (to_cnt == TW'(TIMEOUT_CYC - 1))
            ACTIVE <= 1'b0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: table-driven scoreboard bench for the scan decoder
module tb_seg7_scan_decoder;
    typedef struct {
        logic [3:0]  sa;
        logic [7:0]  seg;
        logic [15:0] dig;
        logic [3:0]  dp;
        int          upd;
        logic        pat;
    } vec_t;

    localparam logic [7:0] P0   = 8'b0000001_1;
    localparam logic [7:0] P3   = 8'b0000110_1;
    localparam logic [7:0] P4D  = 8'b1001100_0;
    localparam logic [7:0] P5   = 8'b0100100_1;
    localparam logic [7:0] P8   = 8'b0000000_1;
    localparam logic [7:0] P9   = 8'b0000100_1;
    localparam logic [7:0] PE   = 8'b0110000_1;
    localparam logic [7:0] PBL  = 8'b1111111_1;
    localparam logic [7:0] PBAD = 8'b1010101_1;

    logic CLK, RESET, CLR_ERR, UPDATE, PAT_ERR, SA_ERR, ACTIVE;
    logic [7:0] SEG_IN;
    logic [3:0] SA_IN, DP_OUT;
    logic [15:0] DIGITS;
    int checks = 0, errors = 0, upd_cnt = 0, cyc = 0, rise_at = -1, fall_at = -1;
    logic act_q = 1'b0;
    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t e;

    seg7_scan_decoder #(.SETTLE_CYC(4), .STABLE_CNT(3), .TIMEOUT_CYC(100)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .SEG_IN  (SEG_IN),
        .SA_IN   (SA_IN),
        .CLR_ERR (CLR_ERR),
        .DIGITS  (DIGITS),
        .DP_OUT  (DP_OUT),
        .UPDATE  (UPDATE),
        .PAT_ERR (PAT_ERR),
        .SA_ERR  (SA_ERR),
        .ACTIVE  (ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output monitor on the falling edge: UPDATE pulse count and ACTIVE edges
    always @(negedge CLK) begin
        cyc++;
        if (UPDATE) upd_cnt++;
        if (ACTIVE && !act_q) rise_at = cyc;
        if (!ACTIVE && act_q) fall_at = cyc;
        act_q = ACTIVE;
    end

    task automatic tick(input int k);
        repeat (k) @(negedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(logic [3:0] sa, logic [7:0] seg, logic [15:0] dig,
                                logic [3:0] dp, int upd, logic pat);
        tbl.push_back('{sa, seg, dig, dp, upd, pat});
    endfunction

    initial begin
        RESET = 1'b0;
        SA_IN = 4'hF;
        SEG_IN = 8'hFF;
        CLR_ERR = 1'b0;
        add(4'b1110, P0, 16'hFFFF, 4'b0000, 0, 0);
        add(4'b1110, P0, 16'hFFFF, 4'b0000, 0, 0);
        add(4'b1110, P0, 16'hFFF0, 4'b0000, 1, 0);
        for (int r = 0; r < 2; r++) begin
            add(4'b1110, P9,  16'hFFF0, 4'b0000, 0, 0);
            add(4'b1101, P4D, 16'hFFF0, 4'b0000, 0, 0);
            add(4'b1011, PE,  16'hFFF0, 4'b0000, 0, 0);
            add(4'b0111, PBL, 16'hFFF0, 4'b0000, 0, 0);
        end
        add(4'b1110, P9,  16'hFFF9, 4'b0000, 1, 0);
        add(4'b1101, P4D, 16'hFF49, 4'b0010, 1, 0);
        add(4'b1011, PE,  16'hFE49, 4'b0010, 1, 0);
        add(4'b0111, PBL, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P5, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P5, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P3, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P5, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P5, 16'hFE49, 4'b0010, 0, 0);
        add(4'b1110, P5, 16'hFE45, 4'b0010, 1, 0);
        add(4'b1110, P5, 16'hFE45, 4'b0010, 0, 0);
        add(4'b1011, PBAD, 16'hFE45, 4'b0010, 0, 1);
        add(4'b1011, PBAD, 16'hFE45, 4'b0010, 0, 1);
        add(4'b1011, PBAD, 16'hFF45, 4'b0010, 1, 1);
        add(4'b1110, P5,   16'hFF45, 4'b0010, 0, 1);
        tick(3);
        check("rst_digits", DIGITS, 16'hFFFF);
        check("rst_dp", DP_OUT, 0);
        check("rst_update", UPDATE, 0);
        check("rst_pat_err", PAT_ERR, 0);
        check("rst_sa_err", SA_ERR, 0);
        check("rst_active", ACTIVE, 0);
        RESET = 1'b1;
        tick(2);
        foreach (tbl[i]) begin
            upd_cnt = 0;
            SA_IN = tbl[i].sa;
            SEG_IN = tbl[i].seg;
            exp_q.push_back(tbl[i]);
            tick(20);
            SA_IN = 4'hF;
            SEG_IN = 8'hFF;
            tick(6);
            e = exp_q.pop_front();
            check($sformatf("v%0d_digits", i), DIGITS, e.dig);
            check($sformatf("v%0d_dp", i), DP_OUT, e.dp);
            check($sformatf("v%0d_updates", i), upd_cnt, e.upd);
            check($sformatf("v%0d_pat_err", i), PAT_ERR, e.pat);
        end
        upd_cnt = 0;
        SA_IN = 4'b1100;
        tick(10);
        check("multi_sa_err", SA_ERR, 1);
        check("multi_pat_err_sticky", PAT_ERR, 1);
        check("multi_digits", DIGITS, 16'hFF45);
        check("multi_updates", upd_cnt, 0);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("clr_set_wins_sa", SA_ERR, 1);
        check("clr_pat_err", PAT_ERR, 0);
        SA_IN = 4'hF;
        tick(4);
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("clr_sa_err", SA_ERR, 0);
        tick(120);
        check("idle_active_low", ACTIVE, 0);
        check("idle_digits_kept", DIGITS, 16'hFF45);
        rise_at = -1;
        fall_at = -1;
        SA_IN = 4'b1110;
        SEG_IN = P5;
        tick(20);
        SA_IN = 4'hF;
        SEG_IN = 8'hFF;
        for (int i = 0; i < 200 && fall_at < 0; i++) tick(1);
        check("timeout_rise_seen", rise_at >= 0, 1);
        check("timeout_fall_seen", fall_at >= 0, 1);
        check("timeout_len", fall_at - rise_at, 100);
        check("timeout_digits_kept", DIGITS, 16'hFF45);
        SA_IN = 4'b1110;
        SEG_IN = P5;
        tick(12);
        check("pre_rst_active", ACTIVE, 1);
        check("pre_rst_digits", DIGITS, 16'hFF45);
        SA_IN = 4'b1101;
        SEG_IN = P8;
        tick(3);
        RESET = 1'b0;
        #1;
        check("mid_rst_digits", DIGITS, 16'hFFFF);
        check("mid_rst_dp", DP_OUT, 0);
        check("mid_rst_update", UPDATE, 0);
        check("mid_rst_pat_err", PAT_ERR, 0);
        check("mid_rst_sa_err", SA_ERR, 0);
        check("mid_rst_active", ACTIVE, 0);
        tick(2);
        RESET = 1'b1;
        upd_cnt = 0;
        tick(20);
        check("post_rst_updates", upd_cnt, 0);
        check("post_rst_digits", DIGITS, 16'hFFFF);
        check("post_rst_dp", DP_OUT, 0);
        SA_IN = 4'hF;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
